// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider with a period counter.
// The divide ratio is loaded through a pending slot. The pending ratio becomes
// active only at a period boundary, so clk_out never glitches.
// Optional build macro: CLK_DIV_ODD_DUTY50_EN. It adds a negedge term that gives
// an exact 50% duty cycle for odd ratios.
// Reset: rst_n is asynchronous and active-high. The block is held in reset while rst_n == 1.
module clk_div_prog #(
  parameter int W           = 8,
  parameter int PW          = 4,
  parameter int DEFAULT_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic [W-1:0]  div_ratio,
  output logic          clk_out,
  output logic          tick,
  output logic [W-1:0]  phase,
  output logic [PW-1:0] period_cnt,
  output logic          ratio_err
);

  localparam logic [W-1:0]  DEF_W  = W'(DEFAULT_DIV);
  localparam logic [W-1:0]  ONE_W  = W'(1);
  localparam logic [W-1:0]  TWO_W  = W'(2);
  localparam logic [PW-1:0] ONE_PW = PW'(1);

  logic [W-1:0]  r_active;
  logic [W-1:0]  r_pend;
  logic          r_pend_vld;
  logic [W-1:0]  r_phase;
  logic          r_clk_pos;
  logic          r_tick;
  logic [PW-1:0] r_pcnt;
  logic          r_err;

  logic          w_wrap;
  logic          w_load_ok;
  logic          w_load_bad;
  logic [W-1:0]  w_next_phase;
  logic [W-1:0]  w_next_active;
  logic [W-1:0]  w_next_pend;
  logic          w_next_pend_vld;
  logic          w_next_clk_pos;

  // Next-state logic: phase advance, ratio hand-over at wrap, and pending-slot update.
  always_comb begin
    w_wrap          = en & (r_phase == (r_active - ONE_W));
    w_load_ok       = load & (div_ratio >= TWO_W);
    w_load_bad      = load & (div_ratio < TWO_W);
    w_next_phase    = r_phase;
    w_next_active   = r_active;
    w_next_pend     = r_pend;
    w_next_pend_vld = r_pend_vld;
    if (en) begin
      if (w_wrap) begin
        w_next_phase = '0;
        if (r_pend_vld) begin
          // The pending ratio governs the period that starts on this edge.
          w_next_active   = r_pend;
          w_next_pend_vld = 1'b0;
        end else begin
          w_next_active   = r_active;
        end
      end else begin
        w_next_phase = r_phase + ONE_W;
      end
    end else begin
      w_next_phase = r_phase;
    end
    // A load on the wrap edge lands in the slot after the hand-over. It therefore
    // applies at the following wrap.
    if (w_load_ok) begin
      w_next_pend     = div_ratio;
      w_next_pend_vld = 1'b1;
    end else begin
      w_next_pend     = w_next_pend;
    end
    w_next_clk_pos = (w_next_phase < (w_next_active >> 1));
  end

  // State and output registers. All of them reset immediately when rst_n rises.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_active   <= DEF_W;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_phase    <= DEF_W - ONE_W;
      r_clk_pos  <= 1'b0;
      r_tick     <= 1'b0;
      r_pcnt     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_pend     <= w_next_pend;
      r_pend_vld <= w_next_pend_vld;
      r_err      <= w_load_bad;
      r_tick     <= w_wrap;
      if (en) begin
        r_active  <= w_next_active;
        r_phase   <= w_next_phase;
        r_clk_pos <= w_next_clk_pos;
        if (w_wrap) begin
          r_pcnt <= r_pcnt + ONE_PW;
        end else begin
          r_pcnt <= r_pcnt;
        end
      end else begin
        r_active  <= r_active;
        r_phase   <= r_phase;
        r_clk_pos <= r_clk_pos;
        r_pcnt    <= r_pcnt;
      end
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic r_clk_neg;

  // Half-cycle extension of the high time, used only while the active ratio is odd.
  always_ff @(negedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_clk_neg <= 1'b0;
    end else if (en) begin
      r_clk_neg <= r_clk_pos;
    end else begin
      r_clk_neg <= r_clk_neg;
    end
  end

  assign clk_out = r_clk_pos | (r_clk_neg & r_active[0]);
`else
  assign clk_out = r_clk_pos;
`endif

  assign tick       = r_tick;
  assign phase      = r_phase;
  assign period_cnt = r_pcnt;
  assign ratio_err  = r_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog with default parameters (W=8, PW=4, DEFAULT_DIV=2).
// It combines a directed vector table, hand-written corner sequences, and a randomized
// run. All of these are checked against a period-level reference model.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] div_ratio = 8'd0;
  logic       clk_out;
  logic       tick;
  logic [7:0] phase;
  logic [3:0] period_cnt;
  logic       ratio_err;

  int total = 0;
  int bad = 0;

  // Reference model state, using plain integers. m_pend == 0 means the slot is empty.
  int m_active, m_pend, m_phase, m_cnt;
  bit m_clk, m_tick, m_err;

  clk_div_prog #(.W(8), .PW(4), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .div_ratio(div_ratio),
    .clk_out(clk_out), .tick(tick), .phase(phase), .period_cnt(period_cnt),
    .ratio_err(ratio_err)
  );

  always #20 clk = ~clk;

  typedef struct {
    bit       v_en;
    bit       v_load;
    int       v_ratio;
    int       x_phase;
    bit       x_tick;
    bit       x_clk;
    bit       x_err;
    int       x_cnt;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 2; m_pend = 0; m_phase = 1; m_cnt = 0;
    m_clk = 1'b0; m_tick = 1'b0; m_err = 1'b0;
  endtask

  // One enabled edge moves one step through the current period. A period lasts
  // m_active cycles, and the output is high for the first floor(N/2) cycles of it.
  task automatic model_step(input bit e, input bit l, input int r);
    int np;
    np = m_pend;
    m_err = l && (r < 2);
    m_tick = 1'b0;
    if (e) begin
      if (m_phase + 1 >= m_active) begin
        if (m_pend != 0) begin
          m_active = m_pend;
          np = 0;
        end
        m_phase = 0;
        m_tick = 1'b1;
        m_cnt = (m_cnt + 1) % 16;
      end else begin
        m_phase = m_phase + 1;
      end
      m_clk = (m_phase < m_active / 2);
    end
    if (l && r >= 2) np = r;
    m_pend = np;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".phase"}, int'(phase), m_phase);
    chk({tag, ".clk_out"}, int'(clk_out), int'(m_clk));
    chk({tag, ".tick"}, int'(tick), int'(m_tick));
    chk({tag, ".period_cnt"}, int'(period_cnt), m_cnt);
    chk({tag, ".ratio_err"}, int'(ratio_err), int'(m_err));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".phase"}, int'(phase), 1);
    chk({tag, ".clk_out"}, int'(clk_out), 0);
    chk({tag, ".tick"}, int'(tick), 0);
    chk({tag, ".period_cnt"}, int'(period_cnt), 0);
    chk({tag, ".ratio_err"}, int'(ratio_err), 0);
  endtask

  // Advance one clk edge with the current inputs, then sample 5 ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(en, load, int'(div_ratio));
    #5;
    chk_model(tag);
  endtask

  // Run with load low until a tick is sampled. Report how many cycles that took,
  // with a bounded budget.
  task automatic wait_tick(input string tag, output int n);
    n = 0;
    load = 1'b0;
    for (int k = 0; k < 300; k++) begin
      cycle(tag);
      n++;
      if (tick) return;
    end
    chk({tag, ".timeout"}, 1, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b1;
    #10;
    rst_n = 1'b0;
    model_reset();
  endtask

  initial begin
    vec_t vecs[15];
    int n, highs, ticks;

    vecs[0]  = '{1, 0, 0, 0, 1, 1, 0, 1};
    vecs[1]  = '{1, 1, 6, 1, 0, 0, 0, 1};
    vecs[2]  = '{1, 0, 0, 0, 1, 1, 0, 2};
    vecs[3]  = '{1, 0, 0, 1, 0, 1, 0, 2};
    vecs[4]  = '{1, 0, 0, 2, 0, 1, 0, 2};
    vecs[5]  = '{1, 0, 0, 3, 0, 0, 0, 2};
    vecs[6]  = '{1, 0, 0, 4, 0, 0, 0, 2};
    vecs[7]  = '{1, 0, 0, 5, 0, 0, 0, 2};
    vecs[8]  = '{1, 0, 0, 0, 1, 1, 0, 3};
    vecs[9]  = '{1, 1, 1, 1, 0, 1, 1, 3};
    vecs[10] = '{1, 1, 0, 2, 0, 1, 1, 3};
    vecs[11] = '{1, 0, 0, 3, 0, 0, 0, 3};
    vecs[12] = '{1, 0, 0, 4, 0, 0, 0, 3};
    vecs[13] = '{1, 0, 0, 5, 0, 0, 0, 3};
    vecs[14] = '{1, 0, 0, 0, 1, 1, 0, 4};

    // Reset state, sampled while reset is held.
    model_reset();
    #500;
    chk_reset_vals("reset");
    en = 1'b1;
    #500;
    rst_n = 1'b0;

    // Default ratio 2 for 640 cycles: one tick every 2nd cycle, so 320 ticks in all.
    ticks = 0;
    for (int k = 0; k < 640; k++) begin
      cycle("default");
      if (tick) ticks++;
    end
    chk("default.tick_count", ticks, 320);
    chk("default.cnt_wrap", int'(period_cnt), 0);

    // Directed table: reload to ratio 6 mid-period, then two invalid loads.
    pulse_reset();
    for (int i = 0; i < 15; i++) begin
      en = vecs[i].v_en;
      load = vecs[i].v_load;
      div_ratio = 8'(vecs[i].v_ratio);
      cycle("table.model");
      chk($sformatf("table%0d.phase", i), int'(phase), vecs[i].x_phase);
      chk($sformatf("table%0d.tick", i), int'(tick), int'(vecs[i].x_tick));
      chk($sformatf("table%0d.clk_out", i), int'(clk_out), int'(vecs[i].x_clk));
      chk($sformatf("table%0d.ratio_err", i), int'(ratio_err), int'(vecs[i].x_err));
      chk($sformatf("table%0d.period_cnt", i), int'(period_cnt), vecs[i].x_cnt);
    end
    load = 1'b0;

    // Enable gating at phase 2 with N=6, plus a load of 8 during the gap.
    cycle("gate.pre");
    cycle("gate.pre");
    chk("gate.start_phase", int'(phase), 2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      load = (k == 3);
      div_ratio = 8'd8;
      cycle("gate.hold");
      chk("gate.phase_frozen", int'(phase), 2);
      chk("gate.tick_zero", int'(tick), 0);
    end
    load = 1'b0;
    en = 1'b1;
    cycle("gate.resume");
    chk("gate.resume3", int'(phase), 3);
    cycle("gate.resume");
    chk("gate.resume4", int'(phase), 4);
    cycle("gate.resume");
    chk("gate.resume5", int'(phase), 5);
    wait_tick("gate.wrap", n);
    chk("gate.wrap_after", n, 1);
    wait_tick("gate.ratio8", n);
    chk("gate.ratio8_period", n, 8);

    // Odd ratio 5: high for 2 cycles and low for 3 cycles, with a tick every 5 cycles.
    load = 1'b1;
    div_ratio = 8'd5;
    cycle("odd.load");
    wait_tick("odd.sync", n);
    highs = int'(clk_out);
    for (int k = 0; k < 4; k++) begin
      cycle("odd.run");
      highs += int'(clk_out);
    end
    chk("odd.high_cycles", highs, 2);
    wait_tick("odd.period", n);
    chk("odd.tick_period", n, 1);
    wait_tick("odd.period2", n);
    chk("odd.tick_period2", n, 5);

    // Mid-operation asynchronous reset with N=8 active and 12 pending.
    load = 1'b1;
    div_ratio = 8'd8;
    cycle("rst.load8");
    wait_tick("rst.sync", n);
    load = 1'b1;
    div_ratio = 8'd12;
    cycle("rst.load12");
    load = 1'b0;
    cycle("rst.run");
    #2;
    rst_n = 1'b1;
    #1;
    chk_reset_vals("rst.async");
    model_reset();
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    ticks = 0;
    for (int k = 0; k < 30; k++) begin
      cycle("rst.after");
      if (tick) ticks++;
    end
    chk("rst.ratio2_ticks", ticks, 15);

    // Randomized run, checked against the model.
    for (int k = 0; k < 2000; k++) begin
      en = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) div_ratio = 8'($urandom_range(0, 40));
      else div_ratio = 8'($urandom_range(0, 12));
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider with period counter; parametrised successor of the fixed divide-by-2 counter block.
- Generates divided clock enable/waveform `clk_out`, a per-period `tick` strobe, and a wrapping count of completed periods.
- Ratio changes are requested with a load strobe and take effect only at a period boundary, so `clk_out` never glitches.
- Sits between the board clock and downstream slow-rate logic (LED scan, UART baud, sampling timers).

Parameters:
- W, 8, width of the divide-ratio and phase counter; legal ratio range 2..2^W-1.
- PW, 4, width of the completed-period counter `period_cnt`.
- DEFAULT_DIV, 2, ratio active after reset; must be in 2..2^W-1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, asynchronous, active-high.
- en, input, 1, count enable; low freezes all state.
- load, input, 1, one-cycle strobe; captures `div_ratio` as the pending ratio.
- div_ratio, input, W, requested divide ratio N.
- clk_out, output, 1, divided waveform, period N clk cycles.
- tick, output, 1, one-cycle pulse at the start of each divided period.
- phase, output, W, current phase counter, 0..N-1.
- period_cnt, output, PW, completed-period count, wraps modulo 2^PW.
- ratio_err, output, 1, one-cycle pulse when a load is rejected.

Behaviour:
- All outputs registered on posedge clk, except the negedge term when the optional feature is enabled.
- Reset (async, immediate, any time including mid-period):
  - active ratio = DEFAULT_DIV; pending slot empty.
  - phase = DEFAULT_DIV-1; clk_out = 0; tick = 0; period_cnt = 0; ratio_err = 0.
- Counting, on each edge with en=1:
  - If phase == active-1: phase <= 0 (wrap); otherwise phase <= phase+1.
  - The first enabled edge after reset therefore wraps phase to 0.
- Wrap edge:
  - If the pending slot is full, active <= pending and the slot is cleared. The new ratio governs the period starting at this phase=0.
  - tick <= 1 for exactly that cycle; period_cnt <= period_cnt+1, wrapping from 2^PW-1 to 0.
  - On all non-wrap edges, tick <= 0.
- Waveform:
  - clk_out (posedge term) <= 1 when next phase < (active>>1), else 0. This uses the ratio valid for the new period.
  - Even N: exactly 50% duty.
  - Odd N without the feature: high (N-1)/2 cycles, low (N+1)/2 cycles.
- Load:
  - If 2 <= div_ratio <= 2^W-1: pending <= div_ratio. A later load before the boundary overwrites it (last wins).
  - If div_ratio < 2: ratio_err pulses 1 cycle; pending and active are unchanged.
- Load on the same edge as a wrap:
  - Does not affect the period starting on that edge.
  - Applies at the following wrap.
- Load with en=0: pending is captured normally and applied at the first wrap after en returns.
- en=0:
  - phase, clk_out, period_cnt and active all hold.
  - tick is forced 0.
  - Resuming continues from the held phase with no extra or dropped cycle.
- period_cnt overflow is silent; there is no sticky flag.

Optional Feature:
- Macro: CLK_DIV_ODD_DUTY50_EN.
- Defined:
  - A negedge register samples the posedge clk_out term; final clk_out = posedge term OR negedge term, but only while active N is odd.
  - Gives a high time of N/2 clk periods (exact 50% duty).
  - The negedge register resets asynchronously to 0 and holds while en=0.
  - Even N behaviour is unchanged.
- Undefined: no negedge logic is present; odd N gives the duty stated above.

Test Plan:
1. Default ratio, 40 ns clk, rst_n deasserted at 1000 ns, en=1, run 640 cycles.
   - clk_out toggles every clk (80 ns period); tick every 2nd cycle.
   - period_cnt steps 1..15,0, wrapping every 16 periods.
2. Even ratio: load div_ratio=6 at phase=0 of a ratio-2 period.
   - Current period ends after 2 cycles.
   - Then clk_out is 3 high/3 low, tick every 6 cycles, phase runs 0..5.
3. Odd ratio: load 5.
   - Macro off: clk_out 80 ns high/120 ns low.
   - Macro on: 100 ns high/100 ns low.
   - Both: tick every 5 cycles.
4. Invalid loads: load div_ratio=1, then div_ratio=0.
   - ratio_err pulses 1 cycle for each.
   - Period and active ratio unchanged; pending unaffected.
5. Enable gating: en=0 for 10 cycles at phase=2 with N=6, plus load=8 during the gap.
   - phase, clk_out and period_cnt are frozen and tick=0 during the gap.
   - On resume, phase continues 3,4,5; ratio 8 takes effect at the next wrap.
6. Reset mid-operation: assert rst_n 7 ns after a clk edge with N=8 and a pending 12.
   - Outputs take their reset values immediately, before the next clk edge.
   - After release, the divider runs at ratio 2 and the pending 12 is discarded.
